// File: rtl/sdram_mport_pkg.sv
// Shared helpers for the multi-port SDRAM front end.
// The command entry struct depends on AW/DW, so each module declares it from its own localparams.
package sdram_mport_pkg;

  // Width of a port index; a single port still gets a 1-bit tag.
  function automatic int port_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_fifo.sv
// Synchronous FIFO with registered pointers; push is ignored when full and pop when empty.
module sdram_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok & ~pop_ok) cnt_d = cnt_q + 1'b1;
    else if (pop_ok & ~push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter: lowest requester at/after the pointer wins; grant is frozen while the
// downstream stalls, and the pointer moves past the winner only when the request is accepted.
module sdram_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          hold_i,
  input  logic          adv_i,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_o
);
  logic [IW-1:0] rr_q, rr_d, lidx_q, pick;
  logic          lock_q, found;

  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // A stalled request keeps its grant even if a lower index becomes eligible.
  assign gnt_o     = lock_q ? lidx_q : pick;
  assign gnt_vld_o = lock_q | found;
  assign rr_d      = (gnt_o == IW'(N-1)) ? '0 : gnt_o + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= '0;
      lidx_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lock_q <= hold_i;
      lidx_q <= gnt_o;
      if (adv_i) rr_q <= rr_d;
    end
  end
endmodule

// File: rtl/avalon_sdram_mport_frontend.sv
// Multi-port Avalon-MM front end: per-port command FIFOs, round-robin onto one bus_req channel,
// and tag-FIFO routing of in-order read responses back to the issuing port.
module avalon_sdram_mport_frontend
  import sdram_mport_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int AW              = 24,
  parameter int DW              = 16,
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        avs_read,
  input  logic [NUM_PORTS-1:0]        avs_write,
  input  logic [NUM_PORTS*AW-1:0]     avs_address,
  input  logic [NUM_PORTS*DW-1:0]     avs_writedata,
  input  logic [NUM_PORTS*DW/8-1:0]   avs_byteenable,
  output logic [NUM_PORTS-1:0]        avs_waitrequest,
  output logic [NUM_PORTS*DW-1:0]     avs_readdata,
  output logic [NUM_PORTS-1:0]        avs_readdatavalid,
  output logic                        bus_req_valid,
  input  logic                        bus_req_ready,
  output logic                        bus_req_write,
  output logic [AW-1:0]               bus_req_address,
  output logic [DW-1:0]               bus_req_writedata,
  output logic [DW/8-1:0]             bus_req_byteenable,
  input  logic                        bus_resp_valid,
  input  logic [DW-1:0]               bus_resp_readdata,
  output logic                        resp_err
);
  localparam int BW = DW / 8;
  localparam int IW = port_idx_w(NUM_PORTS);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t                           head [NUM_PORTS];
  cmd_t                           sel;
  logic [NUM_PORTS-1:0]           empty, full, elig, pop;
  logic [IW-1:0]                  gnt, tag_head;
  logic                           gnt_vld, accept, tag_full, tag_empty;
  logic [NUM_PORTS-1:0]           rdv_q;
  logic [NUM_PORTS-1:0][DW-1:0]   rdata_q;
  logic                           err_q;

  assign accept = bus_req_valid & bus_req_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    cmd_t din;
    // read and write together is taken as a write
    assign din = '{write: avs_write[p],
                   addr:  avs_address[p*AW +: AW],
                   be:    avs_byteenable[p*BW +: BW],
                   wdata: avs_writedata[p*DW +: DW]};

    sdram_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (avs_read[p] | avs_write[p]),
      .din_i   (din),
      .pop_i   (pop[p]),
      .dout_o  (head[p]),
      .empty_o (empty[p]),
      .full_o  (full[p])
    );

    assign avs_waitrequest[p] = full[p];
    assign elig[p]            = ~empty[p] & (head[p].write | ~tag_full);
    assign pop[p]             = accept & (gnt == IW'(p));
  end

  sdram_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (elig),
    .hold_i    (bus_req_valid & ~bus_req_ready),
    .adv_i     (accept),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  always_comb begin
    sel = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (gnt == IW'(p)) sel = head[p];
  end

  assign bus_req_valid      = gnt_vld;
  assign bus_req_write      = sel.write;
  assign bus_req_address    = sel.addr;
  assign bus_req_writedata  = sel.wdata;
  assign bus_req_byteenable = sel.be;

  // Issue-ordered port indices of reads in flight; responses come back in the same order.
  sdram_fifo #(.W(IW), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept & ~sel.write),
    .din_i   (gnt),
    .pop_i   (bus_resp_valid),
    .dout_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rdv_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdv_q <= '0;
      if (bus_resp_valid) begin
        if (tag_empty) err_q <= 1'b1;
        else begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (tag_head == IW'(p)) begin
              rdv_q[p]   <= 1'b1;
              rdata_q[p] <= bus_resp_readdata;
            end
          end
        end
      end
    end
  end

  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;
  assign resp_err          = err_q;
endmodule
